// File: rtl/tank_ctrl_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tank_ctrl_p                                                    |
// | Purpose : per-player tank controller - clamped motion, terrain-following |
// |           Y, edge-triggered aim, cooled/reloading fire FSM, HP and death |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tank_ctrl_p #(
   parameter int          X_MIN         = 0,
   parameter int          X_MAX         = 639,
   parameter int          X_START       = 140,
   parameter int          TANK_SIZE     = 4,
   parameter int          X_STEP        = 1,
   parameter int          AIM_MAX       = 60,
   parameter int          AIM_STEP      = 3,
   parameter int          HP_INIT       = 10,
   parameter int          AMMO_MAX      = 4,
   parameter int          COOL_FRAMES   = 8,
   parameter int          RELOAD_FRAMES = 30,
   parameter logic [7:0]  KEY_LEFT      = 8'h04,
   parameter logic [7:0]  KEY_RIGHT     = 8'h07,
   parameter logic [7:0]  KEY_UP        = 8'h1A,
   parameter logic [7:0]  KEY_DOWN      = 8'h16,
   parameter logic [7:0]  KEY_FIRE      = 8'h2C,
   parameter logic [7:0]  KEY_RELOAD    = 8'h19
)(
   input  logic        frame_clk,
   input  logic        Reset_n,
   input  logic [7:0]  keycode,
   input  logic        enable,
   input  logic [9:0]  terrain_y,
   input  logic        hit,
   input  logic [3:0]  hit_dmg,
   output logic [9:0]  TankX,
   output logic [9:0]  TankY,
   output logic [9:0]  TankS,
   output logic        Direction,
   output logic [6:0]  aim,
   output logic        shoot,
   output logic [2:0]  ammo,
   output logic        reloading,
   output logic [3:0]  HP,
   output logic        alive
);

   localparam int CNT_TOP = (RELOAD_FRAMES > COOL_FRAMES) ? RELOAD_FRAMES : COOL_FRAMES;
   localparam int CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

   localparam logic [10:0]      X_LO        = 11'(X_MIN + TANK_SIZE);
   localparam logic [10:0]      X_HI        = 11'(X_MAX - TANK_SIZE);
   localparam logic [10:0]      STEP_X      = 11'(X_STEP);
   localparam logic [9:0]       X_RST       = 10'(X_START);
   localparam logic [9:0]       SIZE10      = 10'(TANK_SIZE);
   localparam logic [7:0]       AIM_TOP     = 8'(AIM_MAX);
   localparam logic [7:0]       AIM_INC     = 8'(AIM_STEP);
   localparam logic [3:0]       HP_RST      = 4'(HP_INIT);
   localparam logic [2:0]       AMMO_FULL   = 3'(AMMO_MAX);
   localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOL_FRAMES - 1);
   localparam logic [CNT_W-1:0] RELOAD_LOAD = CNT_W'(RELOAD_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      READY  = 2'd0,
      COOL   = 2'd1,
      RELOAD = 2'd2,
      DEAD   = 2'd3
   } fire_state_t;

   fire_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       prev_key;
   logic [7:0]       k;

   logic [9:0]       x_nxt, y_nxt;
   logic             dir_nxt;
   logic [6:0]       aim_nxt;
   logic             shoot_nxt;
   logic [2:0]       ammo_nxt;
   logic [3:0]       hp_nxt;
   logic             alive_nxt;

   logic             press_up, press_down, press_fire, press_reload;
   logic             lethal;
   logic [10:0]      x_ext;
   logic [7:0]       aim_ext;
   logic [3:0]       hp_after;

   assign k            = enable ? keycode : 8'h00;
   assign press_up     = (k == KEY_UP)     && (prev_key != KEY_UP);
   assign press_down   = (k == KEY_DOWN)   && (prev_key != KEY_DOWN);
   assign press_fire   = (k == KEY_FIRE)   && (prev_key != KEY_FIRE);
   assign press_reload = (k == KEY_RELOAD) && (prev_key != KEY_RELOAD);

   assign x_ext    = {1'b0, TankX};
   assign aim_ext  = {1'b0, aim};
   assign hp_after = (HP > hit_dmg) ? (HP - hit_dmg) : 4'd0;
   // alive implies HP>0, so a hit is lethal exactly when it consumes all HP
   assign lethal   = hit && (hit_dmg >= HP);

   assign TankS     = SIZE10;
   assign reloading = (state == RELOAD);

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= READY;
         cnt       <= '0;
         prev_key  <= 8'h00;
         TankX     <= X_RST;
         TankY     <= 10'd0;
         Direction <= 1'b1;
         aim       <= 7'd0;
         shoot     <= 1'b0;
         ammo      <= AMMO_FULL;
         HP        <= HP_RST;
         alive     <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         prev_key  <= k;
         TankX     <= x_nxt;
         TankY     <= y_nxt;
         Direction <= dir_nxt;
         aim       <= aim_nxt;
         shoot     <= shoot_nxt;
         ammo      <= ammo_nxt;
         HP        <= hp_nxt;
         alive     <= alive_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = TankX;
      dir_nxt   = Direction;
      aim_nxt   = aim;
      shoot_nxt = 1'b0;
      ammo_nxt  = ammo;
      hp_nxt    = HP;
      alive_nxt = alive;
      y_nxt     = (terrain_y < SIZE10) ? 10'd0 : (terrain_y - SIZE10);

      if (state != DEAD) begin
         if (k == KEY_LEFT) begin
            dir_nxt = 1'b0;
            x_nxt   = (x_ext < (X_LO + STEP_X)) ? 10'(X_LO) : 10'(x_ext - STEP_X);
         end else if (k == KEY_RIGHT) begin
            dir_nxt = 1'b1;
            x_nxt   = ((x_ext + STEP_X) > X_HI) ? 10'(X_HI) : 10'(x_ext + STEP_X);
         end

         if (press_up) begin
            aim_nxt = ((aim_ext + AIM_INC) > AIM_TOP) ? 7'(AIM_TOP) : 7'(aim_ext + AIM_INC);
         end else if (press_down) begin
            aim_nxt = (aim_ext < AIM_INC) ? 7'd0 : 7'(aim_ext - AIM_INC);
         end

         if (hit) begin
            hp_nxt = hp_after;
         end

         if (lethal) begin
            // death wins over any fire/reload action on the same frame
            hp_nxt    = 4'd0;
            alive_nxt = 1'b0;
            state_nxt = DEAD;
         end else begin
            case (state)
               READY: begin
                  if (press_fire && (ammo != 3'd0)) begin
                     shoot_nxt = 1'b1;
                     ammo_nxt  = ammo - 3'd1;
                     cnt_nxt   = COOL_LOAD;
                     state_nxt = COOL;
                  end else if (press_reload && (ammo < AMMO_FULL)) begin
                     cnt_nxt   = RELOAD_LOAD;
                     state_nxt = RELOAD;
                  end
               end
               COOL: begin
                  if (press_reload && (ammo < AMMO_FULL)) begin
                     cnt_nxt   = RELOAD_LOAD;
                     state_nxt = RELOAD;
                  end else if (cnt == '0) begin
                     state_nxt = READY;
                  end else begin
                     cnt_nxt = cnt - CNT_ONE;
                  end
               end
               RELOAD: begin
                  if (cnt == '0) begin
                     ammo_nxt  = AMMO_FULL;
                     state_nxt = READY;
                  end else begin
                     cnt_nxt = cnt - CNT_ONE;
                  end
               end
               default: begin
                  state_nxt = state;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tank_ctrl_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_tank_ctrl_p                                                 |
// | Purpose : scoreboard bench for tank_ctrl_p against a frame-level model   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tank_ctrl_p;

   localparam logic [7:0] K_L = 8'h04, K_R = 8'h07, K_U = 8'h1A, K_D = 8'h16;
   localparam logic [7:0] K_F = 8'h2C, K_RL = 8'h19;

   logic       frame_clk = 1'b0;
   logic       Reset_n   = 1'b0;
   logic [7:0] keycode   = 8'h00;
   logic       enable    = 1'b0;
   logic [9:0] terrain_y = 10'd0;
   logic       hit       = 1'b0;
   logic [3:0] hit_dmg   = 4'd0;
   logic [9:0] TankX, TankY, TankS;
   logic       Direction, shoot, reloading, alive;
   logic [6:0] aim;
   logic [2:0] ammo;
   logic [3:0] HP;

   tank_ctrl_p dut (
      .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .enable(enable),
      .terrain_y(terrain_y), .hit(hit), .hit_dmg(hit_dmg),
      .TankX(TankX), .TankY(TankY), .TankS(TankS), .Direction(Direction),
      .aim(aim), .shoot(shoot), .ammo(ammo), .reloading(reloading),
      .HP(HP), .alive(alive)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      int x, y, dir, aim, shoot, ammo, rel, hp, alive;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Frame-level model: time is an edge count, cooldown/reload are deadlines
   int   mx, my, mdir, maim, mammo, mhp, malive, mshoot;
   int   edge_no, ready_from, reload_end, in_reload;
   logic [7:0] mprev;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] terr(input int x);
      return 10'((x * 37) % 483);
   endfunction

   task automatic model_reset();
      mx = 140; my = 0; mdir = 1; maim = 0; mammo = 4; mhp = 10; malive = 1; mshoot = 0;
      edge_no = 0; ready_from = 0; reload_end = 0; in_reload = 0; mprev = 8'h00;
   endtask

   task automatic model_step(input logic [7:0] kc, input logic en, input logic h,
                             input logic [3:0] d, input logic [9:0] ty);
      logic [7:0] kk;
      int dmg;
      kk = en ? kc : 8'h00;
      dmg = int'(d);
      edge_no++;
      mshoot = 0;
      if (malive != 0) begin
         if (kk == K_L) begin mdir = 0; mx = (mx - 1 < 4) ? 4 : mx - 1; end
         else if (kk == K_R) begin mdir = 1; mx = (mx + 1 > 635) ? 635 : mx + 1; end
         if (kk == K_U && mprev != K_U) maim = (maim + 3 > 60) ? 60 : maim + 3;
         else if (kk == K_D && mprev != K_D) maim = (maim - 3 < 0) ? 0 : maim - 3;
         if (h && dmg >= mhp) begin
            mhp = 0; malive = 0; in_reload = 0;
         end else begin
            if (h) mhp = mhp - dmg;
            if (in_reload != 0) begin
               if (edge_no == reload_end) begin
                  mammo = 4; in_reload = 0; ready_from = edge_no + 1;
               end
            end else if (kk == K_RL && mprev != K_RL && mammo < 4) begin
               in_reload = 1; reload_end = edge_no + 30;
            end else if (edge_no >= ready_from && kk == K_F && mprev != K_F && mammo > 0) begin
               mshoot = 1; mammo--; ready_from = edge_no + 9;
            end
         end
      end
      my = (int'(ty) < 4) ? 0 : int'(ty) - 4;
      mprev = kk;
   endtask

   // Called at a falling edge; drives one frame, predicts it, waits for the next falling edge
   task automatic frame(input logic [7:0] kc, input logic en, input logic h, input logic [3:0] d);
      logic [9:0] ty;
      exp_t e;
      ty = terr(mx);
      keycode = kc; enable = en; hit = h; hit_dmg = d; terrain_y = ty;
      model_step(kc, en, h, d, ty);
      e.x = mx; e.y = my; e.dir = mdir; e.aim = maim; e.shoot = mshoot;
      e.ammo = mammo; e.rel = in_reload; e.hp = mhp; e.alive = malive;
      sbq.push_back(e);
      @(negedge frame_clk);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0; keycode = 8'h00; enable = 1'b0; hit = 1'b0;
      #2;
      chk("rst_x", TankX, 140);      chk("rst_y", TankY, 0);
      chk("rst_s", TankS, 4);        chk("rst_dir", Direction, 1);
      chk("rst_aim", aim, 0);        chk("rst_shoot", shoot, 0);
      chk("rst_ammo", ammo, 4);      chk("rst_rel", reloading, 0);
      chk("rst_hp", HP, 10);         chk("rst_alive", alive, 1);
      model_reset();
      @(negedge frame_clk);
      @(negedge frame_clk);
      Reset_n = 1'b1;
   endtask

   // Monitor: every clocked frame out of reset has one prediction waiting
   always begin
      exp_t e;
      @(posedge frame_clk);
      #1;
      if (Reset_n && sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("x", TankX, e.x);          chk("y", TankY, e.y);
         chk("dir", Direction, e.dir);  chk("aim", aim, e.aim);
         chk("shoot", shoot, e.shoot);  chk("ammo", ammo, e.ammo);
         chk("reloading", reloading, e.rel);
         chk("hp", HP, e.hp);           chk("alive", alive, e.alive);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] keys [8];
      logic [7:0] cur;
      logic       en;
      int         hold, dead_frames;
      keys[0] = 8'h00; keys[1] = K_L; keys[2] = K_R; keys[3] = K_U;
      keys[4] = K_D;   keys[5] = K_F; keys[6] = K_RL; keys[7] = 8'h00;

      @(negedge frame_clk);
      do_reset();

      // saturation at the right edge, then the left edge
      repeat (600) frame(K_R, 1'b1, 1'b0, 4'd0);
      chk("x_right_sat", TankX, 635);
      chk("dir_right", Direction, 1);
      repeat (631) frame(K_L, 1'b1, 1'b0, 4'd0);
      chk("x_left_sat", TankX, 4);
      chk("dir_left", Direction, 0);

      // aim: held key steps once; climb to the cap; descend to the floor
      repeat (10) frame(K_U, 1'b1, 1'b0, 4'd0);
      chk("aim_hold", aim, 3);
      repeat (25) begin frame(8'h00, 1'b1, 1'b0, 4'd0); frame(K_U, 1'b1, 1'b0, 4'd0); end
      chk("aim_max", aim, 60);
      repeat (23) begin frame(8'h00, 1'b1, 1'b0, 4'd0); frame(K_D, 1'b1, 1'b0, 4'd0); end
      chk("aim_min", aim, 0);

      // five spaced shots, then a press inside the cooldown
      do_reset();
      repeat (5) begin
         frame(K_F, 1'b1, 1'b0, 4'd0);
         repeat (9) frame(8'h00, 1'b1, 1'b0, 4'd0);
      end
      chk("ammo_empty", ammo, 0);
      do_reset();
      frame(K_F, 1'b1, 1'b0, 4'd0);
      frame(8'h00, 1'b1, 1'b0, 4'd0);
      frame(K_F, 1'b1, 1'b0, 4'd0);
      repeat (10) frame(8'h00, 1'b1, 1'b0, 4'd0);

      // reload from one round with fire presses during the reload
      do_reset();
      repeat (3) begin
         frame(K_F, 1'b1, 1'b0, 4'd0);
         repeat (9) frame(8'h00, 1'b1, 1'b0, 4'd0);
      end
      frame(K_RL, 1'b1, 1'b0, 4'd0);
      repeat (5) begin frame(8'h00, 1'b1, 1'b0, 4'd0); frame(K_F, 1'b1, 1'b0, 4'd0); end
      repeat (25) frame(8'h00, 1'b1, 1'b0, 4'd0);
      chk("ammo_reloaded", ammo, 4);

      // reset immediately after a shot and in the middle of a reload
      frame(K_F, 1'b1, 1'b0, 4'd0);
      do_reset();
      frame(K_F, 1'b1, 1'b0, 4'd0);
      frame(K_RL, 1'b1, 1'b0, 4'd0);
      repeat (5) frame(8'h00, 1'b1, 1'b0, 4'd0);
      do_reset();

      // lethal hit coinciding with a fire press, then frozen controls
      frame(8'h00, 1'b1, 1'b1, 4'd7);
      frame(K_F, 1'b1, 1'b1, 4'd5);
      chk("dead_alive", alive, 0);
      chk("dead_hp", HP, 0);
      chk("dead_ammo", ammo, 4);
      repeat (4) begin
         frame(K_R, 1'b1, 1'b0, 4'd0); frame(K_U, 1'b1, 1'b0, 4'd0);
         frame(K_F, 1'b1, 1'b0, 4'd0); frame(8'h00, 1'b1, 1'b0, 4'd0);
      end
      do_reset();

      // randomized play
      hold = 0; dead_frames = 0; cur = 8'h00; en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            cur  = keys[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) cur = 8'($urandom);
            hold = $urandom_range(1, 12);
            en   = ($urandom_range(0, 9) != 0);
         end
         frame(cur, en, ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 6)));
         hold--;
         if (malive == 0) begin
            dead_frames++;
            if (dead_frames > 15) begin
               do_reset();
               dead_frames = 0;
            end
         end
      end

      @(negedge frame_clk);
      chk("scoreboard_drain", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
